// File: rtl/v_mem_seq_pkg.sv
// Shared types and constants for the vector load/store sequencer.
package v_mem_seq_pkg;

  localparam int NUM_BANKS = 4;
  localparam int BANK_BITS = 2;

  localparam int DM_BITS_DEF  = 14;
  localparam int DM_WIDTH_DEF = 32;
  localparam int VL_BITS_DEF  = 6;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_e;

  typedef enum logic {
    ROW,
    ELEM
  } mode_e;

  function automatic logic [NUM_BANKS-1:0] bank_onehot(input logic [BANK_BITS-1:0] bank);
    return NUM_BANKS'(1) << bank;
  endfunction

endpackage

// File: rtl/v_mem_seq_if.sv
// Bus bundle between vector core, sequencer and 4-bank data memory.
// Optional perf counters appear when V_MEM_SEQ_PERF_EN is defined.
interface v_mem_seq_if #(
  parameter int DATAMEM_BITS  = v_mem_seq_pkg::DM_BITS_DEF,
  parameter int DATAMEM_WIDTH = v_mem_seq_pkg::DM_WIDTH_DEF,
  parameter int VL_BITS       = v_mem_seq_pkg::VL_BITS_DEF
);
  localparam int NB = v_mem_seq_pkg::NUM_BANKS;

  logic                     start;
  logic                     is_store;
  logic                     strided;
  logic [DATAMEM_BITS-1:0]  base_addr;
  logic [DATAMEM_BITS-1:0]  stride;
  logic [VL_BITS-1:0]       vl;

  logic                     st_valid;
  logic [DATAMEM_WIDTH-1:0] st_data [NB];
  logic                     st_ready;

  logic                     ld_valid;
  logic [NB-1:0]            ld_mask;
  logic [DATAMEM_WIDTH-1:0] ld_data [NB];

  logic                     busy;
  logic                     done;

  logic [DATAMEM_BITS-1:0]  data_addr;
  logic [3:0]               dm_write [NB];
  logic [DATAMEM_WIDTH-1:0] data_in  [NB];
  logic [DATAMEM_WIDTH-1:0] data_out [NB];

`ifdef V_MEM_SEQ_PERF_EN
  logic [31:0]              perf_beats;
  logic [31:0]              perf_stalls;
`endif

  // Sequencer side.
  modport slave (
    input  start, is_store, strided, base_addr, stride, vl,
    input  st_valid, st_data, data_out,
    output st_ready, ld_valid, ld_mask, ld_data, busy, done,
    output data_addr, dm_write, data_in
`ifdef V_MEM_SEQ_PERF_EN
    , output perf_beats, perf_stalls
`endif
  );

  // Core/memory side.
  modport master (
    output start, is_store, strided, base_addr, stride, vl,
    output st_valid, st_data, data_out,
    input  st_ready, ld_valid, ld_mask, ld_data, busy, done,
    input  data_addr, dm_write, data_in
`ifdef V_MEM_SEQ_PERF_EN
    , input perf_beats, perf_stalls
`endif
  );

endinterface

// File: rtl/v_mem_seq_agen.sv
// Beat/element counter with wrapping address accumulator and bank-enable
// generation (row tail mask or single element bank).
module v_mem_seq_agen import v_mem_seq_pkg::*; #(
  parameter int ADDR_BITS = DM_BITS_DEF,
  parameter int VL_BITS   = VL_BITS_DEF
)(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_load,
  input  logic                 i_advance,
  input  logic                 i_row_mode,
  input  logic [ADDR_BITS-1:0] i_base,
  input  logic [ADDR_BITS-1:0] i_step,
  input  logic [VL_BITS-1:0]   i_vl,
  output logic [ADDR_BITS-1:0] o_addr,
  output logic [NUM_BANKS-1:0] o_bank_en,
  output logic                 o_last
);
  // One extra bit so 4n can reach vl rounded up without overflow.
  localparam int CNT_BITS = VL_BITS + 1;

  logic [ADDR_BITS-1:0] r_addr;
  logic [ADDR_BITS-1:0] r_step;
  logic                 r_row;
  logic [VL_BITS-1:0]   r_vl;
  logic [CNT_BITS-1:0]  r_elem;

  logic [CNT_BITS-1:0]  w_inc;
  logic [CNT_BITS-1:0]  w_vl;
  logic [NUM_BANKS-1:0] w_tail;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_addr <= '0;
      r_step <= '0;
      r_row  <= 1'b0;
      r_vl   <= '0;
      r_elem <= '0;
    end else if (i_load) begin
      r_addr <= i_base;
      r_step <= i_row_mode ? ADDR_BITS'(NUM_BANKS) : i_step;
      r_row  <= i_row_mode;
      r_vl   <= i_vl;
      r_elem <= '0;
    end else if (i_advance) begin
      r_addr <= r_addr + r_step;
      r_elem <= r_elem + w_inc;
    end
  end

  assign w_inc = r_row ? CNT_BITS'(NUM_BANKS) : CNT_BITS'(1);
  assign w_vl  = {1'b0, r_vl};

  always_comb begin
    w_tail = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      w_tail[i] = (r_elem + CNT_BITS'(i)) < w_vl;
    end
  end

  assign o_addr    = r_addr;
  assign o_last    = (r_elem + w_inc) >= w_vl;
  assign o_bank_en = r_row ? w_tail : bank_onehot(r_addr[BANK_BITS-1:0]);

endmodule

// File: rtl/v_mem_seq.sv
// Vector load/store sequencer: splits one vector command into bank beats.
// Define V_MEM_SEQ_PERF_EN to add beat and store-stall counters.
module v_mem_seq import v_mem_seq_pkg::*; #(
  parameter int DATAMEM_BITS  = DM_BITS_DEF,
  parameter int DATAMEM_WIDTH = DM_WIDTH_DEF,
  parameter int VL_BITS       = VL_BITS_DEF
)(
  input  logic        core_clk,
  input  logic        rst,
  v_mem_seq_if.slave  bus
);

  state_e                   r_state;
  state_e                   w_next;
  logic                     r_is_store;
  mode_e                    r_mode;

  logic                     w_start_ok;
  logic                     w_row_start;
  logic                     w_issue;
  logic                     w_last;
  logic [DATAMEM_BITS-1:0]  w_step;
  logic [DATAMEM_BITS-1:0]  w_addr;
  logic [NUM_BANKS-1:0]     w_bank_en;
  logic [NUM_BANKS-1:0]     w_we_bank;
  logic [DATAMEM_WIDTH-1:0] w_elem_data;

  logic                     r_ld_valid;
  mode_e                    r_ld_mode;
  logic [NUM_BANKS-1:0]     r_ld_mask;
  logic [BANK_BITS-1:0]     r_ld_bank;

  assign w_start_ok  = (r_state == IDLE) && bus.start;
  assign w_row_start = !bus.strided && (bus.base_addr[BANK_BITS-1:0] == '0);
  assign w_step      = bus.strided ? bus.stride : DATAMEM_BITS'(1);

  v_mem_seq_agen #(
    .ADDR_BITS (DATAMEM_BITS),
    .VL_BITS   (VL_BITS)
  ) u_agen (
    .i_clk      (core_clk),
    .i_rst      (rst),
    .i_load     (w_start_ok),
    .i_advance  (w_issue),
    .i_row_mode (w_row_start),
    .i_base     (bus.base_addr),
    .i_step     (w_step),
    .i_vl       (bus.vl),
    .o_addr     (w_addr),
    .o_bank_en  (w_bank_en),
    .o_last     (w_last)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge core_clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_is_store <= 1'b0;
      r_mode     <= ROW;
    end else begin
      r_state <= w_next;
      if (w_start_ok) begin
        r_is_store <= bus.is_store;
        r_mode     <= w_row_start ? ROW : ELEM;
      end
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next   = r_state;
    w_issue  = 1'b0;
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) w_next = (bus.vl == '0) ? DONE : ISSUE;
      end
      ISSUE: begin
        bus.busy = 1'b1;
        w_issue  = r_is_store ? bus.st_valid : 1'b1;
        if (w_issue && w_last) w_next = r_is_store ? DONE : DRAIN;
      end
      DRAIN, DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
        w_next   = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Store path: write enables and data are gated so idle/stall cycles drive 0.
  assign w_elem_data   = bus.st_data[0];
  assign w_we_bank     = (w_issue && r_is_store) ? w_bank_en : '0;
  assign bus.st_ready  = w_issue && r_is_store;
  assign bus.data_addr = w_addr;

  always_comb begin
    for (int i = 0; i < NUM_BANKS; i++) begin
      bus.dm_write[i] = {4{w_we_bank[i]}};
      bus.data_in[i]  = '0;
      if (w_we_bank[i]) bus.data_in[i] = (r_mode == ROW) ? bus.st_data[i] : w_elem_data;
    end
  end

  // Load beat context registered to line up with the 1-cycle memory read.
  always_ff @(posedge core_clk or posedge rst) begin
    if (rst) begin
      r_ld_valid <= 1'b0;
      r_ld_mode  <= ROW;
      r_ld_mask  <= '0;
      r_ld_bank  <= '0;
    end else begin
      r_ld_valid <= w_issue && !r_is_store;
      if (w_issue && !r_is_store) begin
        r_ld_mode <= r_mode;
        r_ld_mask <= w_bank_en;
        r_ld_bank <= w_addr[BANK_BITS-1:0];
      end
    end
  end

  assign bus.ld_valid = r_ld_valid;

  always_comb begin
    bus.ld_mask = '0;
    for (int i = 0; i < NUM_BANKS; i++) bus.ld_data[i] = '0;
    if (r_ld_valid) begin
      if (r_ld_mode == ROW) begin
        bus.ld_mask = r_ld_mask;
        for (int i = 0; i < NUM_BANKS; i++) begin
          if (r_ld_mask[i]) bus.ld_data[i] = bus.data_out[i];
        end
      end else begin
        bus.ld_mask    = NUM_BANKS'(1);
        bus.ld_data[0] = bus.data_out[r_ld_bank];
      end
    end
  end

`ifdef V_MEM_SEQ_PERF_EN
  logic [31:0] r_perf_beats;
  logic [31:0] r_perf_stalls;

  always_ff @(posedge core_clk or posedge rst) begin
    if (rst) begin
      r_perf_beats  <= '0;
      r_perf_stalls <= '0;
    end else begin
      if (w_issue) r_perf_beats <= r_perf_beats + 32'd1;
      if ((r_state == ISSUE) && r_is_store && !bus.st_valid)
        r_perf_stalls <= r_perf_stalls + 32'd1;
    end
  end

  assign bus.perf_beats  = r_perf_beats;
  assign bus.perf_stalls = r_perf_stalls;
`endif

endmodule

// File: tb/tb_v_mem_seq.sv
// Self-checking bench for v_mem_seq: bank memory model plus load/store
// scoreboards filled when commands are driven and drained by a monitor.
`timescale 1ns/1ps
module tb_v_mem_seq;
  import v_mem_seq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  v_mem_seq_if bus ();

  v_mem_seq dut (
    .core_clk (clk),
    .rst      (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [13:0]      addr;
    logic [15:0]      we;
    logic [3:0][31:0] data;
  } st_exp_t;

  typedef struct {
    logic [3:0]       mask;
    logic [3:0][31:0] data;
  } ld_exp_t;

  int        n_checks = 0;
  int        n_errors = 0;
  int        ld_seen  = 0;
  st_exp_t   st_q[$];
  ld_exp_t   ld_q[$];
  logic [31:0] mem [4][4096];
  logic [15:0] wr_pack;
  logic [31:0] din_or;
  logic [31:0] ldd_or;

  assign wr_pack = {bus.dm_write[3], bus.dm_write[2], bus.dm_write[1], bus.dm_write[0]};
  assign din_or  = bus.data_in[0] | bus.data_in[1] | bus.data_in[2] | bus.data_in[3];
  assign ldd_or  = bus.ld_data[0] | bus.ld_data[1] | bus.ld_data[2] | bus.ld_data[3];

  function automatic logic [31:0] pat(input int row, input int bank);
    return 32'hB000_005A | (32'(bank) << 24) | (32'(row) << 8);
  endfunction

  function automatic logic [31:0] st_pat(input int beat, input int lane);
    return 32'hD000_0000 | (32'(beat) << 8) | 32'(lane);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Synchronous-read bank memory.
  initial begin
    for (int b = 0; b < 4; b++)
      for (int r = 0; r < 4096; r++) mem[b][r] = pat(r, b);
  end

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      bus.data_out[b] <= mem[b][bus.data_addr[13:2]];
      if (bus.dm_write[b] == 4'hF) mem[b][bus.data_addr[13:2]] = bus.data_in[b];
    end
  end

  always @(negedge clk) begin : monitor
    st_exp_t se;
    ld_exp_t le;
    if (!rst) begin
      if (wr_pack != 16'h0) begin
        if (st_q.size() == 0) check("unexp_wr", wr_pack, 16'h0);
        else begin
          se = st_q.pop_front();
          check("wr_addr", bus.data_addr, se.addr);
          check("wr_en", wr_pack, se.we);
          for (int i = 0; i < 4; i++) check($sformatf("wr_data%0d", i), bus.data_in[i], se.data[i]);
        end
      end
      if (bus.ld_valid) begin
        ld_seen++;
        if (ld_q.size() == 0) check("unexp_ld", bus.ld_valid, 1'b0);
        else begin
          le = ld_q.pop_front();
          check("ld_mask", bus.ld_mask, le.mask);
          for (int i = 0; i < 4; i++) check($sformatf("ld_data%0d", i), bus.ld_data[i], le.data[i]);
        end
      end
    end
  end

  task automatic check_all_zero(input string pfx);
    check({pfx, "_busy"}, bus.busy, 1'b0);
    check({pfx, "_done"}, bus.done, 1'b0);
    check({pfx, "_ldv"}, bus.ld_valid, 1'b0);
    check({pfx, "_strdy"}, bus.st_ready, 1'b0);
    check({pfx, "_ldmask"}, bus.ld_mask, 4'h0);
    check({pfx, "_addr"}, bus.data_addr, 14'h0);
    check({pfx, "_dmw"}, wr_pack, 16'h0);
    check({pfx, "_din"}, din_or, 32'h0);
    check({pfx, "_ldd"}, ldd_or, 32'h0);
  endtask

  // Called at posedge+1: presents a command for one cycle.
  task automatic issue_cmd(input logic st, input logic sd, input logic [13:0] base,
                           input logic [13:0] strd, input int vl);
    bus.is_store  = st;
    bus.strided   = sd;
    bus.base_addr = base;
    bus.stride    = strd;
    bus.vl        = 6'(vl);
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start     = 1'b0;
  endtask

  task automatic run_load(input logic sd, input logic [13:0] base, input logic [13:0] strd, input int vl);
    logic        row;
    logic [13:0] step, a;
    logic [13:0] aq[$];
    ld_exp_t     e;
    int          nb, c, s0;
    row  = !sd && (base[1:0] == 2'b00);
    step = sd ? strd : 14'd1;
    nb   = row ? (vl + 3) / 4 : vl;
    for (int n = 0; n < nb; n++) begin
      a = row ? base + 14'(4 * n) : base + 14'(n) * step;
      aq.push_back(a);
      e.mask = 4'h0;
      e.data = '0;
      if (row) begin
        for (int i = 0; i < 4; i++)
          if (4 * n + i < vl) begin
            e.mask[i] = 1'b1;
            e.data[i] = pat(int'(a[13:2]), i);
          end
      end else begin
        e.mask    = 4'b0001;
        e.data[0] = pat(int'(a[13:2]), int'(a[1:0]));
      end
      ld_q.push_back(e);
    end
    s0 = ld_seen;
    @(posedge clk); #1;
    issue_cmd(1'b0, sd, base, strd, vl);
    for (c = 0; c < nb + 20; c++) begin
      @(negedge clk); #1;
      if (c == 0) check("ld_busy", bus.busy, 1'b1);
      if (c < nb) check($sformatf("ld_addr%0d", c), bus.data_addr, aq[c]);
      if (bus.done) break;
    end
    check("ld_done_cyc", c, nb);
    check("ld_done_with_valid", bus.ld_valid, 1'b1);
    check("ld_beats", ld_seen - s0, nb);
    @(negedge clk); #1;
    check("ld_idle_busy", bus.busy, 1'b0);
    check("ld_idle_done", bus.done, 1'b0);
    check("ld_q_empty", ld_q.size(), 0);
  endtask

  task automatic run_store(input logic sd, input logic [13:0] base, input logic [13:0] strd,
                           input int vl, input int stall_at, input int stall_len);
    logic        row, valid;
    logic [13:0] step, a;
    st_exp_t     se;
    int          nb, beat, stalled, guard;
    row  = !sd && (base[1:0] == 2'b00);
    step = sd ? strd : 14'd1;
    nb   = row ? (vl + 3) / 4 : vl;
    bus.st_valid = 1'b0;
    @(posedge clk); #1;
    issue_cmd(1'b1, sd, base, strd, vl);
    beat = 0; stalled = 0; guard = 0;
    while (beat < nb && guard < 100) begin
      guard++;
      a     = row ? base + 14'(4 * beat) : base + 14'(beat) * step;
      valid = !(beat == stall_at && stalled < stall_len);
      for (int i = 0; i < 4; i++) bus.st_data[i] = st_pat(beat, i);
      bus.st_valid = valid;
      if (valid) begin
        se.addr = a;
        se.we   = 16'h0;
        se.data = '0;
        if (row) begin
          for (int i = 0; i < 4; i++)
            if (4 * beat + i < vl) begin
              se.we[4*i +: 4] = 4'hF;
              se.data[i]      = st_pat(beat, i);
            end
        end else begin
          se.we[4*int'(a[1:0]) +: 4] = 4'hF;
          se.data[int'(a[1:0])]      = st_pat(beat, 0);
        end
        st_q.push_back(se);
      end
      @(negedge clk); #1;
      check("st_ready", bus.st_ready, valid);
      if (!valid) begin
        stalled++;
        check("stall_addr", bus.data_addr, a);
        check("stall_wr", wr_pack, 16'h0);
      end
      @(posedge clk); #1;
      if (valid) beat++;
    end
    bus.st_valid = 1'b0;
    check("st_beats", beat, nb);
    @(negedge clk); #1;
    check("st_done", bus.done, 1'b1);
    check("st_done_busy", bus.busy, 1'b1);
    @(negedge clk); #1;
    check("st_idle_done", bus.done, 1'b0);
    check("st_idle_busy", bus.busy, 1'b0);
    check("st_q_empty", st_q.size(), 0);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    ld_exp_t e;
    bus.start = 1'b0; bus.is_store = 1'b0; bus.strided = 1'b0;
    bus.base_addr = '0; bus.stride = '0; bus.vl = '0; bus.st_valid = 1'b0;
    for (int i = 0; i < 4; i++) bus.st_data[i] = '0;

    @(negedge clk); #1;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    run_load(1'b0, 14'h0040, 14'h0, 8);            // row load, two full beats
    run_store(1'b0, 14'h0100, 14'h0, 6, -1, 0);    // row store, tail mask 0011
    run_load(1'b1, 14'h0005, 14'h6, 3);            // strided load, banks 1,3,1
    run_store(1'b0, 14'h0200, 14'h0, 8, 1, 2);     // row store with 2-cycle stall
    run_store(1'b1, 14'h3FFE, 14'h3, 2, -1, 0);    // strided store wrapping past 0x3FFF
    run_load(1'b0, 14'h0300, 14'h0, 5);            // row load, tail mask 0001
    run_load(1'b0, 14'h0033, 14'h0, 3);            // unaligned unit-stride -> element mode

    // Reset in the middle of a vl=16 load.
    e.mask = 4'hF;
    for (int i = 0; i < 4; i++) e.data[i] = pat(14'h0080 >> 2, i);
    ld_q.push_back(e);
    @(posedge clk); #1;
    issue_cmd(1'b0, 1'b0, 14'h0080, 14'h0, 16);
    @(posedge clk); #1;
    @(negedge clk); #1;
    check("abort_addr", bus.data_addr, 14'h0084);
    check("abort_ldv", bus.ld_valid, 1'b1);
    rst = 1'b1;
    #1;
    check_all_zero("abort");
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_flush", ld_q.size(), 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      check("abort_no_done", bus.done, 1'b0);
      check("abort_no_busy", bus.busy, 1'b0);
    end

    // Zero-length command completes one cycle after start, no memory access.
    @(posedge clk); #1;
    issue_cmd(1'b1, 1'b0, 14'h0010, 14'h0, 0);
    @(negedge clk); #1;
    check("vl0_done", bus.done, 1'b1);
    check("vl0_wr", wr_pack, 16'h0);
    @(negedge clk); #1;
    check("vl0_done_fall", bus.done, 1'b0);
    check("vl0_busy_fall", bus.busy, 1'b0);
    check("vl0_no_wr", st_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
